// File: rtl/if_stage_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package if_stage_pkg;

    localparam int unsigned IF_ADDR_W   = 30;
    localparam logic [31:0] IF_NOP_INSN = 32'h0000_0013;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_REQ  = 2'd1,
        IF_WAIT = 2'd2,
        IF_HOLD = 2'd3
    } if_state_e;

endpackage

// File: rtl/if_hold_buf.sv
// One-entry holding register for a fetch response that arrived while decode stalled.
module if_hold_buf #(
    parameter int unsigned W = 62
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_i,
    input  logic         clr_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    // Next-state: a write takes priority over a clear.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (wr_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (clr_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Buffer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= {W{1'b0}};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC ownership, single-outstanding imem fetch, branch redirect.
// Define IF_BUS_ERR_EN to add imem_err / if_bus_err bus-error reporting.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int unsigned       ADDR_W    = IF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_VEC = {ADDR_W{1'b0}},
    parameter logic [31:0]       NOP_INSN  = IF_NOP_INSN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_addr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic [ADDR_W-1:0] if_pc,
    output logic [31:0]       if_insn,
`ifdef IF_BUS_ERR_EN
    input  logic              imem_err,
    output logic              if_bus_err,
`endif
    output logic              if_en
);

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
`ifdef IF_BUS_ERR_EN
    localparam int unsigned BUF_W = ADDR_W + 33;
`else
    localparam int unsigned BUF_W = ADDR_W + 32;
`endif

    if_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, req_pc_q, req_pc_d, if_pc_q, if_pc_d;
    logic              kill_q, kill_d, if_en_q, if_en_d;
    logic [31:0]       if_insn_q, if_insn_d;

    logic              redirect_s, load_s, buf_wr_s, buf_clr_s, buf_valid_s;
    logic [BUF_W-1:0]  buf_in_s, buf_out_s;
    logic [ADDR_W-1:0] buf_pc_s, ld_pc_s;
    logic [31:0]       buf_insn_s, ld_insn_s;
    logic              rsp_err_s, buf_err_s, ld_err_s;

    assign redirect_s = br_taken & ~stall;

`ifdef IF_BUS_ERR_EN
    assign rsp_err_s = imem_err;
    assign buf_in_s  = {req_pc_q, imem_rdata, imem_err};
    assign {buf_pc_s, buf_insn_s, buf_err_s} = buf_out_s;
`else
    assign rsp_err_s = 1'b0;
    assign buf_err_s = 1'b0;
    assign buf_in_s  = {req_pc_q, imem_rdata};
    assign {buf_pc_s, buf_insn_s} = buf_out_s;
`endif

    if_hold_buf #(.W(BUF_W)) u_hold_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_i    (buf_wr_s),
        .clr_i   (buf_clr_s),
        .data_i  (buf_in_s),
        .valid_o (buf_valid_s),
        .data_o  (buf_out_s)
    );

    // Fetch FSM next-state, PC update and decoder-facing output selection.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        req_pc_d  = req_pc_q;
        kill_d    = kill_q;
        buf_wr_s  = 1'b0;
        buf_clr_s = 1'b0;
        load_s    = 1'b0;
        ld_pc_s   = req_pc_q;
        ld_insn_s = imem_rdata;
        ld_err_s  = rsp_err_s;
        if_pc_d   = if_pc_q;
        if_insn_d = if_insn_q;
        if_en_d   = if_en_q;

        case (state_q)
            IF_IDLE: state_d = IF_REQ;
            IF_REQ: begin
                // A grant in the redirect cycle was for the old PC: its data must be dropped.
                if (imem_gnt) begin
                    state_d  = IF_WAIT;
                    req_pc_d = pc_q;
                    kill_d   = redirect_s;
                end else begin
                    kill_d = 1'b0;
                end
            end
            IF_WAIT: begin
                if (imem_rvalid) begin
                    kill_d = 1'b0;
                    if (kill_q || redirect_s) begin
                        state_d = IF_REQ;
                    end else if (stall) begin
                        buf_wr_s = 1'b1;
                        state_d  = IF_HOLD;
                    end else begin
                        load_s  = 1'b1;
                        state_d = IF_REQ;
                    end
                end else if (redirect_s) begin
                    kill_d = 1'b1;
                end else begin
                    kill_d = kill_q;
                end
            end
            IF_HOLD: begin
                if (redirect_s) begin
                    buf_clr_s = 1'b1;
                    state_d   = IF_REQ;
                end else if (!stall) begin
                    buf_clr_s = 1'b1;
                    state_d   = IF_REQ;
                    load_s    = buf_valid_s;
                    ld_pc_s   = buf_pc_s;
                    ld_insn_s = buf_insn_s;
                    ld_err_s  = buf_err_s;
                end else begin
                    state_d = IF_HOLD;
                end
            end
            default: state_d = IF_IDLE;
        endcase

        if (redirect_s) begin
            pc_d = br_addr;
        end else if (load_s) begin
            pc_d = ld_pc_s + PC_ONE;
        end else begin
            pc_d = pc_q;
        end

        if (stall) begin
            if_pc_d   = if_pc_q;
            if_insn_d = if_insn_q;
            if_en_d   = if_en_q;
        end else if (load_s) begin
            if_pc_d   = ld_pc_s;
            if_insn_d = ld_err_s ? NOP_INSN : ld_insn_s;
            if_en_d   = 1'b1;
        end else begin
            if_pc_d   = if_pc_q;
            if_insn_d = NOP_INSN;
            if_en_d   = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IF_IDLE;
            pc_q      <= RESET_VEC;
            req_pc_q  <= RESET_VEC;
            kill_q    <= 1'b0;
            if_pc_q   <= {ADDR_W{1'b0}};
            if_insn_q <= NOP_INSN;
            if_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            req_pc_q  <= req_pc_d;
            kill_q    <= kill_d;
            if_pc_q   <= if_pc_d;
            if_insn_q <= if_insn_d;
            if_en_q   <= if_en_d;
        end
    end

`ifdef IF_BUS_ERR_EN
    logic if_bus_err_q;

    // Error flag travels with if_en: held on stall, cleared by bubbles and redirects.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_bus_err_q <= 1'b0;
        end else if (stall) begin
            if_bus_err_q <= if_bus_err_q;
        end else if (load_s) begin
            if_bus_err_q <= ld_err_s;
        end else begin
            if_bus_err_q <= 1'b0;
        end
    end

    assign if_bus_err = if_bus_err_q;
`endif

    assign imem_req  = (state_q == IF_REQ);
    assign imem_addr = pc_q;
    assign if_pc     = if_pc_q;
    assign if_insn   = if_insn_q;
    assign if_en     = if_en_q;

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed scenarios then randomized traffic against a
// program-order fetch model and a bench-owned instruction memory.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [29:0] addr;
        logic [31:0] data;
        int          due;
    } rsp_t;

    logic        clk;
    logic        reset, stall, br_taken;
    logic [29:0] br_addr, imem_addr, if_pc;
    logic        imem_req, imem_gnt, imem_rvalid, if_en;
    logic [31:0] imem_rdata, if_insn;
`ifdef IF_BUS_ERR_EN
    logic        imem_err, if_bus_err;
`endif

    if_stage dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_addr     (br_addr),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_pc       (if_pc),
        .if_insn     (if_insn),
`ifdef IF_BUS_ERR_EN
        .imem_err    (imem_err),
        .if_bus_err  (if_bus_err),
`endif
        .if_en       (if_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    rsp_t        pend[$];
    logic [31:0] img [logic [29:0]];
    bit          img_err [logic [29:0]];
    int          cyc = 0, n_cmp = 0, n_fail = 0, n_deliv = 0;
    logic [29:0] exp_pc = 30'd0;
    logic [29:0] last_gnt_addr = 30'd0;
    bit          granted = 1'b0;
    int          force_gnt = -1, rv_lat = -1, force_err = 0;
    bit          fixed_en = 1'b0;
    logic [31:0] fixed_data = 32'd0;

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        return {2'b01, a} ^ 32'h3C5A_96E1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit          g, rv, e, p_reset, p_stall, p_br, p_req, p_en, p_berr;
        logic [29:0] p_br_addr, p_addr, p_pc;
        logic [31:0] p_insn, exp_i, d;
        rsp_t        r;
        int          lat;
        g = 1'b0;
        if (imem_req === 1'b1) begin
            if (force_gnt >= 0) g = (force_gnt != 0);
            else g = ($urandom_range(99, 0) < 60);
        end
        imem_gnt = g;
        rv = 1'b0;
        e  = 1'b0;
        if (pend.size() > 0 && cyc >= pend[0].due) begin
            rv = 1'b1;
            r  = pend[0];
        end
        imem_rvalid = rv;
        imem_rdata  = rv ? r.data : $urandom;
`ifdef IF_BUS_ERR_EN
        if (rv) e = (force_err >= 0) ? (force_err != 0) : ($urandom_range(9, 0) == 0);
        imem_err = e;
        p_berr = if_bus_err;
`else
        p_berr = 1'b0;
`endif
        if (rv) img_err[r.addr] = e;
        p_reset = reset;  p_stall = stall;   p_br = br_taken; p_br_addr = br_addr;
        p_req = imem_req; p_addr = imem_addr; p_pc = if_pc;   p_insn = if_insn; p_en = if_en;

        @(posedge clk);
        #1;
        cyc++;
        if (rv) void'(pend.pop_front());
        granted = p_req && g;
        if (granted) begin
            last_gnt_addr = p_addr;
            d = fixed_en ? fixed_data : mem_word(p_addr);
            img[p_addr] = d;
            lat = (rv_lat >= 0) ? rv_lat : int'($urandom_range(2, 0));
            r.addr = p_addr; r.data = d; r.due = cyc + lat;
            pend.push_back(r);
        end

        if (p_reset) begin
            chk("rst_en", 64'(if_en), 64'd0);
            chk("rst_insn", 64'(if_insn), 64'(NOP));
            chk("rst_pc", 64'(if_pc), 64'd0);
            chk("rst_req", 64'(imem_req), 64'd0);
`ifdef IF_BUS_ERR_EN
            chk("rst_berr", 64'(if_bus_err), 64'd0);
`endif
            exp_pc = 30'd0;
        end else if (p_stall) begin
            chk("hold_en", 64'(if_en), 64'(p_en));
            chk("hold_insn", 64'(if_insn), 64'(p_insn));
            chk("hold_pc", 64'(if_pc), 64'(p_pc));
`ifdef IF_BUS_ERR_EN
            chk("hold_berr", 64'(if_bus_err), 64'(p_berr));
`endif
        end else if (p_br) begin
            chk("br_en", 64'(if_en), 64'd0);
            chk("br_insn", 64'(if_insn), 64'(NOP));
            exp_pc = p_br_addr;
        end else if (if_en === 1'b1) begin
            n_deliv++;
            exp_i = img.exists(exp_pc) ? img[exp_pc] : 32'hxxxx_xxxx;
            e = img_err.exists(exp_pc) ? img_err[exp_pc] : 1'b0;
            chk("dlv_pc", 64'(if_pc), 64'(exp_pc));
            chk("dlv_insn", 64'(if_insn), 64'(e ? NOP : exp_i));
`ifdef IF_BUS_ERR_EN
            chk("dlv_berr", 64'(if_bus_err), 64'(e));
`endif
            exp_pc = exp_pc + 30'd1;
        end else begin
            chk("bub_insn", 64'(if_insn), 64'(NOP));
        end

        // An ungranted request must stay put unless a redirect moved it.
        if (!p_reset && p_req && !granted && !(p_br && !p_stall)) begin
            chk("req_hold", 64'(imem_req), 64'd1);
            chk("addr_hold", 64'(imem_addr), 64'(p_addr));
        end
    endtask

    task automatic sync_req();
        force_gnt = 0; stall = 1'b0; br_taken = 1'b0;
        for (int i = 0; i < 20 && !(imem_req === 1'b1 && pend.size() == 0); i++) tick();
        chk("sync_req", 64'(imem_req), 64'd1);
    endtask

    task automatic wait_grant();
        force_gnt = 1;
        granted = 1'b0;
        for (int i = 0; i < 10 && !granted; i++) tick();
        chk("grant_seen", 64'(granted), 64'd1);
    endtask

    task automatic wait_en();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            seen = (if_en === 1'b1);
        end
        chk("en_seen", 64'(seen), 64'd1);
    endtask

    initial begin
        logic [29:0] a0;
        int          d0;
        reset = 1'b1; stall = 1'b0; br_taken = 1'b0; br_addr = 30'd0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
`ifdef IF_BUS_ERR_EN
        imem_err = 1'b0;
`endif
        // 1: back-to-back fetch, one instruction every second cycle
        force_gnt = 1; rv_lat = 0; fixed_en = 1'b1; fixed_data = 32'h00F6_A093;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("t1_req", 64'(imem_req), 64'd1);
        chk("t1_addr0", 64'(imem_addr), 64'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t1_en", 64'(if_en), 64'(i % 2));
            if (i % 2 == 0) begin
                chk("t1_gnt", 64'(granted), 64'd1);
                chk("t1_gnt_addr", 64'(last_gnt_addr), 64'(i / 2));
            end else begin
                chk("t1_pc", 64'(if_pc), 64'((i - 1) / 2));
                chk("t1_insn", 64'(if_insn), 64'h00F6_A093);
            end
        end

        // 2: response arrives under stall, parked until stall drops
        sync_req();
        fixed_data = 32'hF016_8093;
        wait_grant();
        a0 = last_gnt_addr;
        force_gnt = 0; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_req_low", 64'(imem_req), 64'd0);
        end
        stall = 1'b0;
        tick();
        chk("t2_en", 64'(if_en), 64'd1);
        chk("t2_insn", 64'(if_insn), 64'hF016_8093);
        chk("t2_pc", 64'(if_pc), 64'(a0));
        chk("t2_req", 64'(imem_req), 64'd1);
        chk("t2_next", 64'(imem_addr), 64'(a0 + 30'd1));

        // 3: redirect while waiting drops the response
        fixed_en = 1'b0;
        sync_req();
        br_taken = 1'b1; br_addr = 30'd5;
        tick();
        br_taken = 1'b0;
        chk("t3_addr5", 64'(imem_addr), 64'd5);
        rv_lat = 2;
        wait_grant();
        chk("t3_gnt5", 64'(last_gnt_addr), 64'd5);
        force_gnt = 0; br_taken = 1'b1; br_addr = 30'd15;
        tick();
        br_taken = 1'b0;
        chk("t3_en0", 64'(if_en), 64'd0);
        rv_lat = 0;
        wait_grant();
        chk("t3_gnt15", 64'(last_gnt_addr), 64'd15);
        wait_en();
        chk("t3_pc15", 64'(if_pc), 64'd15);

        // 4: redirect beats same-cycle rvalid; redirect under stall ignored
        sync_req();
        wait_grant();
        force_gnt = 0; br_taken = 1'b1; br_addr = 30'h20;
        tick();
        br_taken = 1'b0;
        chk("t4_en0", 64'(if_en), 64'd0);
        wait_grant();
        chk("t4_gnt20", 64'(last_gnt_addr), 64'h20);
        wait_en();
        chk("t4_pc20", 64'(if_pc), 64'h20);
        sync_req();
        a0 = imem_addr;
        stall = 1'b1; br_taken = 1'b1; br_addr = 30'h99;
        tick();
        stall = 1'b0; br_taken = 1'b0;
        chk("t4_stall_br", 64'(imem_addr), 64'(a0));
        wait_grant();
        chk("t4_gnt_keep", 64'(last_gnt_addr), 64'(a0));

        // 5: grant withheld, then reset mid-request with a stale response
        sync_req();
        a0 = imem_addr;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_req", 64'(imem_req), 64'd1);
            chk("t5_addr", 64'(imem_addr), 64'(a0));
        end
        rv_lat = 3;
        wait_grant();
        force_gnt = 0; reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_stale", 64'(if_en), 64'd0);
        end
        rv_lat = 0;
        wait_grant();
        chk("t5_gnt0", 64'(last_gnt_addr), 64'd0);
        wait_en();
        chk("t5_pc0", 64'(if_pc), 64'd0);

`ifdef IF_BUS_ERR_EN
        // 6: bus error response
        sync_req();
        br_taken = 1'b1; br_addr = 30'd3;
        tick();
        br_taken = 1'b0;
        force_err = 1;
        wait_grant();
        force_gnt = 0;
        tick();
        force_err = 0;
        chk("t6_berr", 64'(if_bus_err), 64'd1);
        chk("t6_insn", 64'(if_insn), 64'h0000_0013);
        chk("t6_pc", 64'(if_pc), 64'd3);
        chk("t6_en", 64'(if_en), 64'd1);
`endif

        // 7: PC wraps at the top of the word-address space
        sync_req();
        br_taken = 1'b1; br_addr = 30'h3FFF_FFFF;
        tick();
        br_taken = 1'b0; force_gnt = 1;
        wait_en();
        chk("t7_top", 64'(if_pc), 64'h3FFF_FFFF);
        wait_en();
        chk("t7_wrap", 64'(if_pc), 64'd0);

        // Randomized traffic
        force_gnt = -1; rv_lat = -1; force_err = -1;
        d0 = n_deliv;
        for (int i = 0; i < 3000; i++) begin
            stall    = ($urandom_range(99, 0) < 25);
            br_taken = ($urandom_range(99, 0) < 4);
            br_addr  = ($urandom_range(1, 0) == 0) ? 30'($urandom_range(63, 0)) : 30'($urandom);
            tick();
        end
        stall = 1'b0; br_taken = 1'b0;
        chk("rand_progress", 64'((n_deliv - d0) > 200), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
